// File: rtl/pipe_boot_loader.sv
// pipe_boot_loader: word-stream program loader for the pipelined core.
// Optionally zeroes the register file after reset, then parses
// header-framed bursts into IMEM/DMEM/REGFILE writes and holds the
// core in reset until a GO header arrives, counting run cycles after.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   host word handshake, in_data = header or payload
//   wr_en/wr_sel        one-cycle write strobe, target 0 IM 1 DM 2 RF
//   wr_addr/wr_data     word index within target and write data
//   cpu_reset           core reset, released by GO
//   load_err            sticky out-of-range burst flag
//   run_cycles          saturating cycle count since release
module pipe_boot_loader #(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int NREGS      = 32,
    parameter bit CLEAR_REGS = 1'b1,
    parameter int ADDR_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              cpu_reset,
    output logic              load_err,
    output logic [31:0]       run_cycles
);

    localparam int CW = $clog2(NREGS + 1);
    localparam logic [16:0] IM_D = 17'(IMEM_DEPTH);
    localparam logic [16:0] DM_D = 17'(DMEM_DEPTH);
    localparam logic [16:0] RF_D = 17'(NREGS);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_HDR,
        S_LOAD,
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     clr_idx_q, clr_idx_d;
    logic [1:0]        tgt_q, tgt_d;
    logic [15:0]       start_q, start_d;
    logic [13:0]       count_q, count_d;
    logic [13:0]       n_q, n_d;
    logic              disc_q, disc_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_err_q, load_err_d;
    logic [31:0]       run_q, run_d;

    logic        accept;
    logic [1:0]  hdr_tgt;
    logic [13:0] hdr_cnt;
    logic [15:0] hdr_start;
    logic [16:0] hdr_sum;
    logic [16:0] hdr_depth;
    logic [15:0] ld_idx;

    assign accept    = in_valid & in_ready_q;
    assign hdr_tgt   = in_data[31:30];
    assign hdr_cnt   = in_data[29:16];
    assign hdr_start = in_data[15:0];
    // 17-bit sum so start + count can never wrap past the depth check
    assign hdr_sum   = {1'b0, hdr_start} + {3'b000, hdr_cnt};
    assign ld_idx    = start_q + {2'b00, n_q};

    always_comb begin
        case (hdr_tgt)
            2'd1:    hdr_depth = DM_D;
            2'd2:    hdr_depth = RF_D;
            default: hdr_depth = IM_D;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        tgt_d       = tgt_q;
        start_d     = start_q;
        count_d     = count_q;
        n_d         = n_q;
        disc_d      = disc_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_reset_d = cpu_reset_q;
        load_err_d  = load_err_q;
        run_d       = run_q;
        unique case (state_q)
            S_CLEAR: begin
                // index runs one past the last entry so in_ready
                // rises only after the final clear write is visible
                if (clr_idx_q == CW'(NREGS)) begin
                    state_d = S_HDR;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = 2'd2;
                    wr_addr_d = ADDR_W'(clr_idx_q);
                    wr_data_d = '0;
                    clr_idx_d = clr_idx_q + CW'(1);
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (hdr_tgt == 2'd3) begin
                        state_d     = S_RUN;
                        cpu_reset_d = 1'b0;
                    end else if (hdr_cnt != 14'd0) begin
                        tgt_d   = hdr_tgt;
                        start_d = hdr_start;
                        count_d = hdr_cnt;
                        n_d     = 14'd0;
                        disc_d  = hdr_sum > hdr_depth;
                        if (hdr_sum > hdr_depth) begin
                            load_err_d = 1'b1;
                        end
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (!disc_q) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = tgt_q;
                        wr_addr_d = ADDR_W'(ld_idx);
                        wr_data_d = in_data;
                    end
                    n_d = n_q + 14'd1;
                    if (n_q == count_q - 14'd1) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_RUN: begin
                if (run_q != 32'hFFFF_FFFF) begin
                    run_d = run_q + 32'd1;
                end
            end
        endcase
        in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR_REGS ? S_CLEAR : S_HDR;
            clr_idx_q   <= '0;
            tgt_q       <= 2'd0;
            start_q     <= 16'd0;
            count_q     <= 14'd0;
            n_q         <= 14'd0;
            disc_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 2'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            load_err_q  <= 1'b0;
            run_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            tgt_q       <= tgt_d;
            start_q     <= start_d;
            count_q     <= count_d;
            n_q         <= n_d;
            disc_q      <= disc_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            load_err_q  <= load_err_d;
            run_q       <= run_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_err   = load_err_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_pipe_boot_loader.sv
// tb_pipe_boot_loader: randomized bursts against a transaction-level
// model of expected writes, flags and handshake timing.
module tb_pipe_boot_loader;

    localparam int NREGS = 32;
    localparam int IMD   = 64;
    localparam int DMD   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        load_err;
    logic [31:0] run_cycles;

    pipe_boot_loader #(
        .WIDTH(32), .IMEM_DEPTH(IMD), .DMEM_DEPTH(DMD),
        .NREGS(NREGS), .CLEAR_REGS(1'b1), .ADDR_W(16)
    ) dut (
        .clock(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_reset(cpu_reset),
        .load_err(load_err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; an event "at edge e"
    // is visible at the falling edge where cyc == e
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] pay_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          go_edge = -1;
    int          err_edge = -1;
    int          ready_edge = 1 << 30;
    bit          mon_en = 1'b0;
    bit          mon_due;
    bit          mon_go;
    wr_t         mon_e;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_due = exp_q.size() > 0 && exp_q[0].edge_n == cyc;
            mon_go  = go_edge >= 0 && cyc >= go_edge;
            check("wr_en", 64'(wr_en), 64'(mon_due));
            if (mon_due) begin
                mon_e = exp_q.pop_front();
                check("wr_sel", 64'(wr_sel), 64'(mon_e.sel));
                check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(wr_data), 64'(mon_e.data));
            end
            check("in_ready", 64'(in_ready),
                  64'(cyc >= ready_edge && !mon_go));
            check("cpu_reset", 64'(cpu_reset), 64'(!mon_go));
            check("load_err", 64'(load_err),
                  64'(err_edge >= 0 && cyc >= err_edge));
            check("run_cycles", 64'(run_cycles),
                  mon_go ? 64'(cyc - go_edge) : 64'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // returns the edge number at which the word transfers
    task automatic send_word(input logic [31:0] d, input int gap,
                             output int acc);
        int n;
        n = 0;
        repeat (gap) begin
            tick();
            in_valid = 1'b0;
        end
        tick();
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
            acc = -1;
        end else begin
            acc = cyc + 1;
        end
    endtask

    task automatic burst(input int tgt, input int start, input int cnt,
                         input int maxgap, input int nsend);
        int          e;
        int          depth;
        bit          disc;
        logic [31:0] h;
        logic [31:0] d;
        h = {tgt[1:0], cnt[13:0], start[15:0]};
        send_word(h, int'($urandom_range(maxgap, 0)), e);
        if (tgt == 3) begin
            go_edge = e;
            return;
        end
        if (cnt == 0) return;
        depth = (tgt == 0) ? IMD : (tgt == 1) ? DMD : NREGS;
        disc  = (start + cnt) > depth;
        if (disc && err_edge < 0) err_edge = e;
        for (int i = 0; i < cnt && i < nsend; i++) begin
            d = (pay_q.size() > 0) ? pay_q.pop_front() : $urandom;
            send_word(d, int'($urandom_range(maxgap, 0)), e);
            if (!disc) exp_q.push_back('{e, tgt[1:0], 16'(start + i), d});
        end
    endtask

    task automatic do_reset(input int r);
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        go_edge    = -1;
        err_edge   = -1;
        ready_edge = cyc + r + NREGS + 1;
        for (int i = 0; i < NREGS; i++)
            exp_q.push_back('{cyc + r + 1 + i, 2'd2, 16'(i), 32'd0});
        repeat (r) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_sel", 64'(wr_sel), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_run", 64'(run_cycles), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        int tgt;
        int cnt;
        int start;
        int depth;
        do_reset(3);
        mon_en = 1'b1;
        repeat (NREGS + 2) tick();

        pay_q = '{32'h20082000, 32'h01294826, 32'h014a5026};
        burst(0, 0, 3, 0, 99);
        pay_q = '{32'h20082000, 32'h01294826, 32'h014a5026};
        burst(0, 0, 3, 3, 99);

        burst(1, 62, 2, 0, 99);
        burst(1, 63, 2, 0, 99);
        burst(0, 20, 2, 1, 99);

        burst(1, 5, 0, 0, 99);
        burst(0, 7, 2, 0, 99);

        for (int k = 0; k < 30; k++) begin
            tgt   = int'($urandom_range(2, 0));
            depth = (tgt == 0) ? IMD : (tgt == 1) ? DMD : NREGS;
            cnt   = int'($urandom_range(6, 0));
            if ($urandom_range(1, 0) == 1)
                start = int'($urandom_range(depth - 1, 0));
            else
                start = depth - cnt + int'($urandom_range(2, 0)) - 1;
            burst(tgt, start, cnt, int'($urandom_range(2, 0)), 99);
        end
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        burst(0, 10, 3, 0, 1);
        do_reset(2);
        repeat (NREGS + 2) tick();

        burst(2, 4, 3, 1, 99);
        burst(1, 40, 4, 0, 99);
        burst(3, 0, 0, 0, 99);
        tick();
        in_data = $urandom;
        repeat (12) tick();
        in_valid = 1'b0;
        repeat (2) tick();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
